// File: rtl/uart_tx_line_feeder.sv
// uart_tx_line_feeder
// Takes one fixed-length ASCII line, waits until the UART TX FIFO reports room
// for a whole line, then bursts the characters (optionally followed by CR LF)
// into the FIFO write port at one byte per clock.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no line held; o_line_ready=1, a request is latched here
// ST_WAIT | line latched, waiting for i_tx_ready before starting burst
// ST_SEND | a line character is on o_tx_data; index counts bytes issued
// ST_CR   | 8'h0D is on o_tx_data
// ST_LF   | 8'h0A is on o_tx_data; returns to ST_IDLE on the next edge
//
// The registered outputs always describe the state being occupied, so each
// transition loads the byte that belongs to the state being entered. This is
// what makes o_line_ready fall back to 1 only after the last byte has been
// presented, rather than in the same cycle.

module uart_tx_line_feeder #(
    parameter int parm_ascii_line_length = 35,
    parameter bit parm_append_crlf       = 1'b1
) (
    input  logic                                  i_clk_40mhz,
    input  logic                                  i_rst_40mhz,
    input  logic [8*parm_ascii_line_length-1:0]   i_line_ascii,
    input  logic                                  i_line_valid,
    output logic                                  o_line_ready,
    output logic                                  o_line_dropped,
    output logic [7:0]                            o_tx_data,
    output logic                                  o_tx_valid,
    input  logic                                  i_tx_ready
);

    localparam int LINE_W = 8 * parm_ascii_line_length;
    localparam int IDX_W  = $clog2(parm_ascii_line_length) + 1;
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(parm_ascii_line_length);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SEND,
        ST_CR,
        ST_LF
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    index;
    logic [LINE_W-1:0]   line_reg;

    // Ready is the only combinational output: it mirrors the idle state.
    assign o_line_ready = (state == ST_IDLE);

    // Line sequencer: latch, wait for FIFO room, then burst chars and CR LF.
    // The line register shifts left so the next character is always on top.
    always_ff @(posedge i_clk_40mhz) begin
        if (i_rst_40mhz) begin
            state          <= ST_IDLE;
            index          <= '0;
            line_reg       <= '0;
            o_tx_valid     <= 1'b0;
            o_tx_data      <= 8'h00;
            o_line_dropped <= 1'b0;
        end else begin
            o_line_dropped <= i_line_valid && (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    o_tx_valid <= 1'b0;
                    if (i_line_valid) begin
                        line_reg <= i_line_ascii;
                        index    <= '0;
                        state    <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (i_tx_ready) begin
                        o_tx_valid <= 1'b1;
                        o_tx_data  <= line_reg[LINE_W-1 -: 8];
                        line_reg   <= line_reg << 8;
                        index      <= index + IDX_W'(1);
                        state      <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (index == IDX_END) begin
                        if (parm_append_crlf) begin
                            o_tx_valid <= 1'b1;
                            o_tx_data  <= 8'h0D;
                            state      <= ST_CR;
                        end else begin
                            o_tx_valid <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end else begin
                        o_tx_valid <= 1'b1;
                        o_tx_data  <= line_reg[LINE_W-1 -: 8];
                        line_reg   <= line_reg << 8;
                        index      <= index + IDX_W'(1);
                    end
                end

                ST_CR: begin
                    o_tx_valid <= 1'b1;
                    o_tx_data  <= 8'h0A;
                    state      <= ST_LF;
                end

                ST_LF: begin
                    o_tx_valid <= 1'b0;
                    state      <= ST_IDLE;
                end

                default: begin
                    o_tx_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_line_feeder.sv
// Bench for uart_tx_line_feeder: one instance with a 35-char line plus CR LF,
// one with a 4-char line and no CR LF. Expected bytes go into a queue per
// instance when a line is requested; a negedge monitor pops and compares on
// every write strobe. The stimulus task checks timing (latency, contiguity,
// ready and dropped pulses) from cycle arithmetic.

module tb_uart_tx_line_feeder;

    localparam int NA = 35;
    localparam int NB = 4;

    logic              i_clk_40mhz = 1'b0;
    always #5 i_clk_40mhz = ~i_clk_40mhz;

    logic              rst_a = 1'b1;
    logic [8*NA-1:0]   line_a = '0;
    logic              line_valid_a = 1'b0;
    logic              line_ready_a;
    logic              line_dropped_a;
    logic [7:0]        tx_data_a;
    logic              tx_valid_a;
    logic              tx_ready_a = 1'b0;

    logic              rst_b = 1'b1;
    logic [8*NB-1:0]   line_b = '0;
    logic              line_valid_b = 1'b0;
    logic              line_ready_b;
    logic              line_dropped_b;
    logic [7:0]        tx_data_b;
    logic              tx_valid_b;
    logic              tx_ready_b = 1'b0;

    uart_tx_line_feeder #(
        .parm_ascii_line_length (NA),
        .parm_append_crlf       (1'b1)
    ) dut_a (
        .i_clk_40mhz    (i_clk_40mhz),
        .i_rst_40mhz    (rst_a),
        .i_line_ascii   (line_a),
        .i_line_valid   (line_valid_a),
        .o_line_ready   (line_ready_a),
        .o_line_dropped (line_dropped_a),
        .o_tx_data      (tx_data_a),
        .o_tx_valid     (tx_valid_a),
        .i_tx_ready     (tx_ready_a)
    );

    uart_tx_line_feeder #(
        .parm_ascii_line_length (NB),
        .parm_append_crlf       (1'b0)
    ) dut_b (
        .i_clk_40mhz    (i_clk_40mhz),
        .i_rst_40mhz    (rst_b),
        .i_line_ascii   (line_b),
        .i_line_valid   (line_valid_b),
        .o_line_ready   (line_ready_b),
        .o_line_dropped (line_dropped_b),
        .o_tx_data      (tx_data_b),
        .o_tx_valid     (tx_valid_b),
        .i_tx_ready     (tx_ready_b)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    logic [7:0]  line_chars[NA];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the next expected byte.
    always @(negedge i_clk_40mhz) begin
        if (tx_valid_a === 1'b1) begin
            if (exp_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_a_unexpected: actual write %02h required none", tx_data_a);
            end else begin
                check("sb_a_data", 32'(tx_data_a), 32'(exp_a.pop_front()));
            end
        end
        if (tx_valid_b === 1'b1) begin
            if (exp_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_b_unexpected: actual write %02h required none", tx_data_b);
            end else begin
                check("sb_b_data", 32'(tx_data_b), 32'(exp_b.pop_front()));
            end
        end
    end

    function automatic logic get_valid(input bit sel);
        return sel ? tx_valid_b : tx_valid_a;
    endfunction

    function automatic logic get_ready(input bit sel);
        return sel ? line_ready_b : line_ready_a;
    endfunction

    function automatic logic get_dropped(input bit sel);
        return sel ? line_dropped_b : line_dropped_a;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic r);
        if (sel) begin
            line_valid_b = v;
            tx_ready_b   = r;
        end else begin
            line_valid_a = v;
            tx_ready_a   = r;
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) line_chars[i] = 8'($urandom_range(32, 126));
    endtask

    task automatic junk_line(input bit sel);
        if (sel) line_b = $urandom();
        else for (int i = 0; i < NA; i++) line_a[8*i +: 8] = 8'($urandom_range(0, 255));
    endtask

    // Called just after a negedge with the selected DUT idle. Requests the line
    // in line_chars, holds i_tx_ready low for 'stall' waiting cycles, optionally
    // jitters i_tx_ready during the burst, optionally fires a second request in
    // burst cycle 'inject', optionally resets the DUT in burst cycle 'abort_at'.
    task automatic run_line(input bit sel, input int stall, input bit jitter,
                            input int inject, input int abort_at);
        int n;
        int len;
        n   = sel ? NB : NA;
        len = sel ? NB : NA + 2;
        for (int i = 0; i < n; i++) begin
            if (sel) begin
                line_b[8*(NB-1-i) +: 8] = line_chars[i];
                exp_b.push_back(line_chars[i]);
            end else begin
                line_a[8*(NA-1-i) +: 8] = line_chars[i];
                exp_a.push_back(line_chars[i]);
            end
        end
        if (!sel) begin
            exp_a.push_back(8'h0D);
            exp_a.push_back(8'h0A);
        end
        check("req_ready", 32'(get_ready(sel)), 32'd1);
        drive(sel, 1'b1, stall == 0);

        for (int c = 1; c <= stall + 1; c++) begin
            @(negedge i_clk_40mhz);
            check("wait_no_write", 32'(get_valid(sel)), 32'd0);
            check("wait_not_ready", 32'(get_ready(sel)), 32'd0);
            check("wait_no_drop", 32'(get_dropped(sel)), 32'd0);
            drive(sel, 1'b0, c >= stall + 1);
        end

        for (int k = 0; k < len; k++) begin
            @(negedge i_clk_40mhz);
            check("burst_valid", 32'(get_valid(sel)), 32'd1);
            check("burst_not_ready", 32'(get_ready(sel)), 32'd0);
            check("burst_drop", 32'(get_dropped(sel)), 32'(inject >= 0 && k == inject + 1));
            if (k == abort_at) begin
                if (sel) rst_b = 1'b1; else rst_a = 1'b1;
                drive(sel, 1'b0, 1'b1);
                @(negedge i_clk_40mhz);
                check("abort_no_write", 32'(get_valid(sel)), 32'd0);
                check("abort_ready", 32'(get_ready(sel)), 32'd1);
                check("abort_no_drop", 32'(get_dropped(sel)), 32'd0);
                if (sel) begin
                    exp_b.delete();
                    rst_b = 1'b0;
                end else begin
                    exp_a.delete();
                    rst_a = 1'b0;
                end
                return;
            end
            if (k == inject) begin
                junk_line(sel);
                drive(sel, 1'b1, jitter ? 1'($urandom_range(0, 1)) : 1'b1);
            end else begin
                drive(sel, 1'b0, jitter ? 1'($urandom_range(0, 1)) : 1'b1);
            end
        end

        @(negedge i_clk_40mhz);
        check("post_no_write", 32'(get_valid(sel)), 32'd0);
        check("post_ready", 32'(get_ready(sel)), 32'd1);
        check("post_drop", 32'(get_dropped(sel)), 32'(inject == len - 1));
        drive(sel, 1'b0, 1'b1);
    endtask

    initial begin
        int inj;
        repeat (3) @(negedge i_clk_40mhz);
        check("rst_a_ready", 32'(line_ready_a), 32'd1);
        check("rst_a_valid", 32'(tx_valid_a), 32'd0);
        check("rst_a_data", 32'(tx_data_a), 32'h00);
        check("rst_a_drop", 32'(line_dropped_a), 32'd0);
        check("rst_b_ready", 32'(line_ready_b), 32'd1);
        check("rst_b_valid", 32'(tx_valid_b), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Basic line "ABC..." with FIFO room available immediately
        for (int i = 0; i < NA; i++) line_chars[i] = 8'(8'h41 + i);
        run_line(1'b0, 0, 1'b0, -1, -1);

        // Long FIFO back-pressure before the burst
        fill_random(NA);
        run_line(1'b0, 100, 1'b0, -1, -1);

        // i_tx_ready toggling during the burst must not disturb it
        fill_random(NA);
        run_line(1'b0, 2, 1'b1, -1, -1);

        // Second request mid-burst, then a normal line
        fill_random(NA);
        run_line(1'b0, 0, 1'b0, 5, -1);
        fill_random(NA);
        run_line(1'b0, 1, 1'b0, -1, -1);

        // Request in the LF cycle is still dropped
        fill_random(NA);
        run_line(1'b0, 0, 1'b0, NA + 1, -1);

        // Reset at byte 10, then a fresh line must start from char 0
        fill_random(NA);
        run_line(1'b0, 0, 1'b0, -1, 10);
        for (int i = 0; i < NA; i++) line_chars[i] = 8'(8'h41 + i);
        run_line(1'b0, 0, 1'b0, -1, -1);

        // Randomized lines
        for (int t = 0; t < 8; t++) begin
            fill_random(NA);
            inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NA + 1)) : -1;
            run_line(1'b0, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), inj, -1);
        end
        check("sb_a_drained", 32'(exp_a.size()), 32'd0);

        // Short line without CR LF, back-to-back requests
        line_chars[0] = 8'h54;
        line_chars[1] = 8'h45;
        line_chars[2] = 8'h53;
        line_chars[3] = 8'h54;
        run_line(1'b1, 0, 1'b0, -1, -1);
        run_line(1'b1, 0, 1'b0, -1, -1);
        for (int t = 0; t < 6; t++) begin
            fill_random(NB);
            inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
            run_line(1'b1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), inj, -1);
        end
        fill_random(NB);
        run_line(1'b1, 0, 1'b0, -1, 2);
        fill_random(NB);
        run_line(1'b1, 0, 1'b0, -1, -1);

        repeat (3) @(negedge i_clk_40mhz);
        check("sb_a_empty", 32'(exp_a.size()), 32'd0);
        check("sb_b_empty", 32'(exp_b.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
